// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register of the 5-stage MIPS datapath.
//               Captures decoded operands, immediate, register addresses
//               and control bits. Supports hazard stall (hold) and flush
//               (bubble insertion), and keeps a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int BCNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [8:0]         id_ctrl,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [8:0]         ex_ctrl,
    output logic [BCNT_W-1:0]  bubble_cnt
);

    localparam logic [BCNT_W-1:0] c_BCNT_MAX = '1;
    localparam logic [BCNT_W-1:0] c_BCNT_ONE = {{(BCNT_W-1){1'b0}}, 1'b1};

    logic               r_valid;
    logic [DATA_W-1:0]  r_pc4;
    logic [DATA_W-1:0]  r_rd1;
    logic [DATA_W-1:0]  r_rd2;
    logic [DATA_W-1:0]  r_imm;
    logic [RADDR_W-1:0] r_rs;
    logic [RADDR_W-1:0] r_rt;
    logic [RADDR_W-1:0] r_rd;
    logic [8:0]         r_ctrl;
    logic [BCNT_W-1:0]  r_bcnt;

    // A bubble enters EX on a flush, or on a normal load of an empty ID slot.
    // A stalled edge never counts, even if ID is empty.
    logic w_bubble;
    assign w_bubble = flush | (~stall & ~id_valid);

    // Pipeline payload: flush clears, stall holds, otherwise load from ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid <= id_valid;
            r_pc4   <= id_pc4;
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_rd    <= id_rd;
            // An invalid slot must never carry write/memory side effects.
            r_ctrl  <= id_valid ? id_ctrl : 9'd0;
        end
    end

    // Saturating bubble counter; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else if (w_bubble && (r_bcnt != c_BCNT_MAX)) begin
            r_bcnt <= r_bcnt + c_BCNT_ONE;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc4     = r_pc4;
    assign ex_rd1     = r_rd1;
    assign ex_rd2     = r_rd2;
    assign ex_imm     = r_imm;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_rd      = r_rd;
    assign ex_ctrl    = r_ctrl;
    assign bubble_cnt = r_bcnt;

endmodule
`default_nettype wire
